// File: rtl/atm_session_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : atm_session_initiator
//  Purpose  : Runs one ATM session per host request: drives the ATM-side
//             request fields, holds them, samples card_declined, closes the
//             session and returns a response to the host.
//  Options  : define ATM_SESSION_TIMEOUT_EN to abandon a response the host
//             does not accept within TIMEOUT_CYCLES cycles.
//  Revision : 1.0  initial release
// ============================================================================
module atm_session_initiator #(
  parameter int HOLD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  // host request
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [9:0]  req_card,
  input  logic [10:0] req_exp,
  input  logic [9:0]  req_password,
  input  logic [2:0]  req_operation,
  input  logic [9:0]  req_amount,
  input  logic [9:0]  req_destination,
  input  logic [9:0]  req_new_password,
  // ATM side
  output logic [9:0]  credit_number,
  output logic [9:0]  destination,
  output logic [9:0]  withdraw,
  output logic [10:0] expiration_date,
  output logic [9:0]  password,
  output logic [9:0]  new_password,
  output logic [2:0]  operation,
  output logic        exit,
  input  logic        card_declined,
  // host response
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_declined,
  output logic        rsp_illegal,
  output logic        rsp_timeout,
  output logic [7:0]  sessions_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SAMPLE = 3'd2,
    S_CLOSE  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  localparam logic [3:0] c_HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_hold_cnt, w_hold_nxt;
  logic [9:0]  w_credit_nxt, w_dest_nxt, w_wd_nxt, w_pwd_nxt, w_npw_nxt;
  logic [10:0] w_exp_nxt;
  logic [2:0]  w_op_nxt;
  logic        w_exit_nxt, w_rsp_valid_nxt, w_decl_nxt, w_ill_nxt, w_ready_nxt;
  logic [7:0]  w_sess_nxt;
  logic        w_accept, w_legal;

`ifdef ATM_SESSION_TIMEOUT_EN
  localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]  r_to_cnt, w_to_cnt_nxt;
  logic        w_timeout_nxt;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign w_accept = req_valid && req_ready;
  assign w_legal  = (req_operation != 3'b000) && (req_operation != 3'b111);

  // Next-state and next-output computation; every output is re-registered.
  always_comb begin
    w_state_nxt     = r_state;
    w_hold_nxt      = r_hold_cnt;
    w_credit_nxt    = credit_number;
    w_dest_nxt      = destination;
    w_wd_nxt        = withdraw;
    w_exp_nxt       = expiration_date;
    w_pwd_nxt       = password;
    w_npw_nxt       = new_password;
    w_op_nxt        = operation;
    w_exit_nxt      = exit;
    w_rsp_valid_nxt = rsp_valid;
    w_decl_nxt      = rsp_declined;
    w_ill_nxt       = rsp_illegal;
    w_sess_nxt      = sessions_done;
`ifdef ATM_SESSION_TIMEOUT_EN
    w_to_cnt_nxt    = r_to_cnt;
    w_timeout_nxt   = rsp_timeout;
`endif
    case (r_state)
      S_IDLE: begin
`ifdef ATM_SESSION_TIMEOUT_EN
        w_to_cnt_nxt = 8'd0;
`endif
        if (w_accept) begin
          if (w_legal) begin
            w_state_nxt  = S_DRIVE;
            w_hold_nxt   = c_HOLD_LOAD;
            w_credit_nxt = req_card;
            // A transfer names its own target; otherwise the ATM still
            // needs a valid card here, so reuse the customer's card.
            w_dest_nxt   = (req_operation == 3'b011) ? req_destination : req_card;
            w_wd_nxt     = (req_operation == 3'b010 || req_operation == 3'b011)
                           ? req_amount : 10'd0;
            w_exp_nxt    = req_exp;
            w_pwd_nxt    = req_password;
            w_npw_nxt    = (req_operation == 3'b101) ? req_new_password : req_password;
            w_op_nxt     = req_operation;
            w_exit_nxt   = 1'b0;
          end else begin
            // Unsupported opcode: answer immediately, ATM is never touched.
            w_state_nxt     = S_RESP;
            w_ill_nxt       = 1'b1;
            w_decl_nxt      = 1'b1;
            w_rsp_valid_nxt = 1'b1;
          end
        end
      end
      S_DRIVE: begin
        if (r_hold_cnt == 4'd0) begin
          w_state_nxt = S_SAMPLE;
        end else begin
          w_hold_nxt = r_hold_cnt - 4'd1;
        end
      end
      S_SAMPLE: begin
        w_decl_nxt  = card_declined;
        w_ill_nxt   = 1'b0;
        w_state_nxt = S_CLOSE;
        w_exit_nxt  = 1'b1;
        w_op_nxt    = 3'b000;
      end
      S_CLOSE: begin
        w_state_nxt     = S_RESP;
        w_rsp_valid_nxt = 1'b1;
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_sess_nxt      = sessions_done + 8'd1;
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
`ifdef ATM_SESSION_TIMEOUT_EN
        else if (r_to_cnt == c_TO_LAST) begin
          w_rsp_valid_nxt = 1'b0;
          w_timeout_nxt   = 1'b1;
          w_state_nxt     = S_IDLE;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 8'd1;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_ready_nxt = (w_state_nxt == S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_hold_cnt      <= 4'd0;
      req_ready       <= 1'b0;
      credit_number   <= 10'd0;
      destination     <= 10'd0;
      withdraw        <= 10'd0;
      expiration_date <= 11'd0;
      password        <= 10'd0;
      new_password    <= 10'd0;
      operation       <= 3'b000;
      exit            <= 1'b1;
      rsp_valid       <= 1'b0;
      rsp_declined    <= 1'b0;
      rsp_illegal     <= 1'b0;
      sessions_done   <= 8'd0;
`ifdef ATM_SESSION_TIMEOUT_EN
      r_to_cnt        <= 8'd0;
      rsp_timeout     <= 1'b0;
`endif
    end else begin
      r_state         <= w_state_nxt;
      r_hold_cnt      <= w_hold_nxt;
      req_ready       <= w_ready_nxt;
      credit_number   <= w_credit_nxt;
      destination     <= w_dest_nxt;
      withdraw        <= w_wd_nxt;
      expiration_date <= w_exp_nxt;
      password        <= w_pwd_nxt;
      new_password    <= w_npw_nxt;
      operation       <= w_op_nxt;
      exit            <= w_exit_nxt;
      rsp_valid       <= w_rsp_valid_nxt;
      rsp_declined    <= w_decl_nxt;
      rsp_illegal     <= w_ill_nxt;
      sessions_done   <= w_sess_nxt;
`ifdef ATM_SESSION_TIMEOUT_EN
      r_to_cnt        <= w_to_cnt_nxt;
      rsp_timeout     <= w_timeout_nxt;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_atm_session_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_atm_session_initiator
//  Purpose  : Self-checking bench for atm_session_initiator: directed
//             sessions followed by randomized ones, checked against a
//             transaction-level model of the session rules.
//  Options  : honours ATM_SESSION_TIMEOUT_EN like the design.
//  Revision : 1.0  initial release
// ============================================================================
module tb_atm_session_initiator;

  localparam int c_HOLD = 2;
  localparam int c_TO   = 4;

  logic        clock, reset;
  logic        req_valid, req_ready;
  logic [9:0]  req_card, req_password, req_amount, req_destination, req_new_password;
  logic [10:0] req_exp;
  logic [2:0]  req_operation;
  logic [9:0]  credit_number, destination, withdraw, password, new_password;
  logic [10:0] expiration_date;
  logic [2:0]  operation;
  logic        exit, card_declined;
  logic        rsp_valid, rsp_ready, rsp_declined, rsp_illegal, rsp_timeout;
  logic [7:0]  sessions_done;

  atm_session_initiator #(.HOLD_CYCLES(c_HOLD), .TIMEOUT_CYCLES(c_TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_card(req_card),
    .req_exp(req_exp), .req_password(req_password), .req_operation(req_operation),
    .req_amount(req_amount), .req_destination(req_destination),
    .req_new_password(req_new_password),
    .credit_number(credit_number), .destination(destination), .withdraw(withdraw),
    .expiration_date(expiration_date), .password(password),
    .new_password(new_password), .operation(operation), .exit(exit),
    .card_declined(card_declined),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_declined(rsp_declined),
    .rsp_illegal(rsp_illegal), .rsp_timeout(rsp_timeout),
    .sessions_done(sessions_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [9:0]  card;
    logic [10:0] expd;
    logic [9:0]  pwd;
    logic [2:0]  op;
    logic [9:0]  amt;
    logic [9:0]  dst;
    logic [9:0]  npw;
    logic        decl;
  } txn_t;

  int n_cmp = 0;
  int n_mis = 0;
  int model_sessions = 0;
  int completed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  // Count of ATM fields that disagree with what the request asks for.
  function automatic int atm_diff(input txn_t t);
    logic [9:0] e_dst, e_wd, e_npw;
    int d;
    e_dst = (t.op == 3'd3) ? t.dst : t.card;
    e_wd  = (t.op == 3'd2 || t.op == 3'd3) ? t.amt : 10'd0;
    e_npw = (t.op == 3'd5) ? t.npw : t.pwd;
    d = 0;
    if (credit_number   !== t.card) d++;
    if (destination     !== e_dst)  d++;
    if (withdraw        !== e_wd)   d++;
    if (expiration_date !== t.expd) d++;
    if (password        !== t.pwd)  d++;
    if (new_password    !== e_npw)  d++;
    return d;
  endfunction

  // mode: 0 normal, 1 reset during DRIVE, 2 host stalls the response.
  task automatic run_txn(input txn_t t, input int ready_delay, input int mode);
    bit legal, aborted;
    int lat, lowcnt, atm_bad, close_bad, stable_bad, hi, w;
    logic e_decl, e_ill;
    legal   = (t.op != 3'd0) && (t.op != 3'd7);
    e_decl  = legal ? t.decl : 1'b1;
    e_ill   = legal ? 1'b0 : 1'b1;
    aborted = 0; lat = 0; lowcnt = 0; atm_bad = 0; close_bad = 0; stable_bad = 0;
    w = 0;
    while (req_ready !== 1'b1 && w < 50) begin @(negedge clock); w++; end
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_card = t.card; req_exp = t.expd; req_password = t.pwd;
    req_operation = t.op; req_amount = t.amt; req_destination = t.dst;
    req_new_password = t.npw; card_declined = ~t.decl;
    req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_card = 10'($urandom); req_exp = 11'($urandom); req_password = 10'($urandom);
    req_operation = 3'($urandom); req_amount = 10'($urandom);
    req_destination = 10'($urandom); req_new_password = 10'($urandom);
    for (int k = 1; k <= 40 && lat == 0 && !aborted; k++) begin
      @(negedge clock);
      if (k == 1) chk("req_ready_busy", 32'(req_ready), 32'd0);
      if (mode == 1 && k == 1) begin
        reset = 1'b1;
        @(posedge clock); #1;
        model_sessions = 0;
        chk("abort_exit", 32'(exit), 32'd1);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_sessions", 32'(sessions_done), 32'(model_sessions));
        chk("abort_withdraw", 32'(withdraw), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        aborted = 1;
      end else begin
        if (exit === 1'b0) begin lowcnt++; atm_bad += atm_diff(t); end
        if (legal && k == c_HOLD + 2) begin
          if (exit !== 1'b1) close_bad++;
          if (operation !== 3'd0) close_bad++;
          close_bad += atm_diff(t);
        end
        if (rsp_valid === 1'b1) lat = k;
        card_declined = (k == c_HOLD + 1) ? t.decl : ~t.decl;
        req_valid = (k <= c_HOLD) ? 1'($urandom) : 1'b0;
      end
    end
    req_valid = 1'b0;
    if (!aborted) begin
      chk("latency", 32'(lat), legal ? 32'(c_HOLD + 3) : 32'd1);
      chk("exit_low_cycles", 32'(lowcnt), legal ? 32'(c_HOLD + 1) : 32'd0);
      if (legal) begin
        chk("atm_fields", 32'(atm_bad), 32'd0);
        chk("close_cycle", 32'(close_bad), 32'd0);
      end
      chk("rsp_declined", 32'(rsp_declined), 32'(e_decl));
      chk("rsp_illegal", 32'(rsp_illegal), 32'(e_ill));
      if (mode == 2) begin
        hi = 1;
`ifdef ATM_SESSION_TIMEOUT_EN
        w = 0;
        while (rsp_valid === 1'b1 && w < 20) begin
          @(negedge clock); w++;
          if (rsp_valid === 1'b1) hi++;
        end
        chk("timeout_valid_cycles", 32'(hi), 32'(c_TO));
        chk("timeout_flag", 32'(rsp_timeout), 32'd1);
        chk("timeout_sessions", 32'(sessions_done), 32'(model_sessions));
        chk("timeout_req_ready", 32'(req_ready), 32'd1);
`else
        for (int i = 0; i < 299; i++) begin
          @(negedge clock);
          if (rsp_valid === 1'b1 && rsp_declined === e_decl) hi++;
        end
        chk("stall_valid_cycles", 32'(hi), 32'd300);
        chk("stall_timeout_flag", 32'(rsp_timeout), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        model_sessions = (model_sessions + 1) % 256;
        completed++;
        @(negedge clock);
        chk("stall_sessions", 32'(sessions_done), 32'(model_sessions));
`endif
      end else begin
        for (int i = 0; i < ready_delay; i++) begin
          @(negedge clock);
          if (rsp_valid !== 1'b1 || rsp_declined !== e_decl || rsp_illegal !== e_ill)
            stable_bad++;
        end
        chk("rsp_stable", 32'(stable_bad), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        model_sessions = (model_sessions + 1) % 256;
        completed++;
        @(negedge clock);
        chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        chk("sessions_done", 32'(sessions_done), 32'(model_sessions));
        chk("req_ready_back", 32'(req_ready), 32'd1);
      end
    end
  endtask

  function automatic txn_t mk(input int card, input int expd, input int pwd,
                              input int op, input int amt, input int dst,
                              input int npw, input int decl);
    txn_t t;
    t.card = 10'(card); t.expd = 11'(expd); t.pwd = 10'(pwd); t.op = 3'(op);
    t.amt = 10'(amt); t.dst = 10'(dst); t.npw = 10'(npw); t.decl = 1'(decl);
    return t;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Directed sessions, then random ones up to a full sessions_done wrap.
  initial begin
    txn_t t;
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; card_declined = 1'b0;
    req_card = '0; req_exp = '0; req_password = '0; req_operation = '0;
    req_amount = '0; req_destination = '0; req_new_password = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_exit", 32'(exit), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_sessions", 32'(sessions_done), 32'd0);
    chk("reset_operation", 32'(operation), 32'd0);
    chk("reset_credit", 32'(credit_number), 32'd0);
    chk("reset_timeout", 32'(rsp_timeout), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("first_req_ready", 32'(req_ready), 32'd1);

    run_txn(mk(100, 2025, 100, 1, 0, 999, 0, 0), 0, 1);      // reset in DRIVE
    run_txn(mk(100, 2025, 100, 1, 0, 999, 0, 0), 0, 0);      // balance, dest=card
    run_txn(mk(100, 2025, 100, 2, 500, 0, 0, 1), 1, 0);      // withdraw, declined
    run_txn(mk(100, 2025, 100, 3, 321, 200, 0, 0), 2, 0);    // transfer
    run_txn(mk(100, 2025, 100, 7, 10, 20, 30, 0), 0, 0);     // illegal 111
    run_txn(mk(77, 1999, 555, 0, 10, 20, 30, 0), 3, 0);      // illegal 000
    run_txn(mk(42, 2030, 123, 5, 9, 8, 777, 0), 1, 0);       // change password

    while (completed < 256) begin
      t = mk(int'($urandom_range(0, 1023)), int'($urandom_range(0, 2047)),
             int'($urandom_range(0, 1023)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
             int'($urandom_range(0, 1023)), int'($urandom_range(0, 1)));
      run_txn(t, int'($urandom_range(0, 3)), 0);
    end
    chk("wrap_256", 32'(sessions_done), 32'd0);

    run_txn(mk(300, 1500, 400, 4, 0, 0, 0, 0), 0, 2);        // host stalls

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
